// File: rtl/digital_mem_responder_if.sv
// Digital-style external memory link: request from the RAM bridge, data/ready back.
interface digital_mem_responder_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] digital_mem_addr;
    logic            digital_mem_read_en;
    logic            digital_mem_write_en;
    logic [3:0]      digital_mem_byte_size;
    logic [XLEN-1:0] digital_mem_wdata;
    logic [XLEN-1:0] digital_mem_data;
    logic            digital_mem_ready;

    modport master (
        output digital_mem_addr, digital_mem_read_en, digital_mem_write_en,
               digital_mem_byte_size, digital_mem_wdata,
        input  digital_mem_data, digital_mem_ready
    );
    modport slave (
        input  digital_mem_addr, digital_mem_read_en, digital_mem_write_en,
               digital_mem_byte_size, digital_mem_wdata,
        output digital_mem_data, digital_mem_ready
    );
endinterface

// File: rtl/digital_mem_responder.sv
// Byte-addressed memory responder with programmable ready latency.
// Stands in for the off-chip RAM where the Digital RAM component is unavailable.
module digital_mem_lane #(
    parameter int ADDR_WIDTH = 12,
    parameter int LANE       = 0,
    parameter int NB_W       = 3
) (
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [NB_W-1:0]       nbytes,
    output logic [ADDR_WIDTH-1:0] lane_addr,
    output logic                  lane_we
);
    // Address arithmetic is ADDR_WIDTH bits wide, so lanes wrap at DEPTH.
    assign lane_addr = base + ADDR_WIDTH'(LANE);
    assign lane_we   = nbytes > NB_W'(LANE);
endmodule

module digital_mem_responder #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic                    ramclk,
    input  logic                    rst,
    digital_mem_responder_if.slave  bus
);
    localparam int NUM_LANES = XLEN / 8;
    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int NB_W      = $clog2(NUM_LANES + 1);
    localparam int LAT_W     = 8;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef struct packed {
        logic                  is_wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [3:0]            size;
        logic [XLEN-1:0]       wdata;
    } req_t;

    function automatic logic [NB_W-1:0] size_bytes(input logic [3:0] s);
        case (s)
            4'b0001:          size_bytes = NB_W'(1);
            4'b0010:          size_bytes = NB_W'(2);
            4'b0100:          size_bytes = NB_W'(3);
            4'b1000, 4'b1111: size_bytes = NB_W'(4);
            default:          size_bytes = '0;
        endcase
    endfunction

    logic [7:0] mem [DEPTH];

    state_t                               state, nstate;
    logic [LAT_W-1:0]                     cnt, cnt_n;
    logic                                 run, req, access, ready;
    logic [XLEN-1:0]                      data;
    req_t                                 live, cap, acc;
    logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] lane_addr;
    logic [NUM_LANES-1:0]                 lane_we;
    logic [NUM_LANES-1:0][7:0]            rd_bytes;
    logic [NB_W-1:0]                      nbytes;
    logic                                 unused_addr_hi;

    assign unused_addr_hi = ^bus.digital_mem_addr[XLEN-1:ADDR_WIDTH];

    // run blocks the first edge after reset release, so a memory write can
    // never be committed from an edge seen while reset is still asserted.
    assign req = run & (bus.digital_mem_read_en | bus.digital_mem_write_en);

    assign live.is_wr = bus.digital_mem_write_en;
    assign live.addr  = bus.digital_mem_addr[ADDR_WIDTH-1:0];
    assign live.size  = bus.digital_mem_byte_size;
    assign live.wdata = bus.digital_mem_wdata;

    // In IDLE the access (LATENCY==0) happens at the capture edge itself.
    assign acc    = (state == IDLE) ? live : cap;
    assign nbytes = acc.is_wr ? size_bytes(acc.size) : '0;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        digital_mem_lane #(.ADDR_WIDTH(ADDR_WIDTH), .LANE(i), .NB_W(NB_W)) u_lane (
            .base      (acc.addr),
            .nbytes    (nbytes),
            .lane_addr (lane_addr[i]),
            .lane_we   (lane_we[i])
        );
        assign rd_bytes[i] = mem[lane_addr[i]];
    end

    always_comb begin
        nstate = state;
        cnt_n  = cnt;
        access = 1'b0;
        case (state)
            IDLE: if (req) begin
                if (LATENCY == 0) begin
                    access = 1'b1;
                    nstate = RESP;
                end else begin
                    nstate = BUSY;
                    cnt_n  = LAT_W'(LATENCY);
                end
            end
            BUSY: begin
                if (!req) begin
                    nstate = IDLE;
                    cnt_n  = '0;
                end else begin
                    cnt_n = cnt - 1'b1;
                    if (cnt == LAT_W'(1)) begin
                        access = 1'b1;
                        nstate = RESP;
                    end
                end
            end
            RESP:    if (!req) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge ramclk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            run   <= 1'b0;
            ready <= 1'b0;
            data  <= '0;
            cap   <= '0;
        end else begin
            state <= nstate;
            cnt   <= cnt_n;
            run   <= 1'b1;
            if (state == IDLE && req) cap <= live;
            if (access) begin
                ready <= 1'b1;
                if (!acc.is_wr) data <= rd_bytes;
            end else if (state == RESP && !req) begin
                ready <= 1'b0;
            end
        end
    end

    always_ff @(posedge ramclk) begin
        if (access && acc.is_wr)
            for (int i = 0; i < NUM_LANES; i++)
                if (lane_we[i]) mem[lane_addr[i]] <= acc.wdata[8*i +: 8];
    end

    assign bus.digital_mem_data  = data;
    assign bus.digital_mem_ready = ready;
endmodule

// File: tb/tb_digital_mem_responder.sv
// Randomized bench: three responders (LATENCY 2, 3, 0) against a byte-array model.
module tb_digital_mem_responder;
    logic        ramclk = 1'b0;
    logic        rst    = 1'b0;
    logic [2:0]  rd_s, wr_s;
    logic [31:0] addr_s  [3];
    logic [31:0] wdata_s [3];
    logic [3:0]  size_s  [3];
    logic [31:0] data_o  [3];
    logic        rdy_o   [3];

    logic [7:0]  mem_m   [3][4096];
    logic [31:0] last_rd [3];
    int          checks = 0;
    int          errors = 0;

    always #5 ramclk = ~ramclk;

    digital_mem_responder_if #(.XLEN(32)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        digital_mem_responder #(
            .XLEN(32), .ADDR_WIDTH(12), .LATENCY((g == 0) ? 2 : (g == 1) ? 3 : 0)
        ) u_dut (
            .ramclk (ramclk),
            .rst    (rst),
            .bus    (bus[g])
        );
        assign bus[g].digital_mem_addr      = addr_s[g];
        assign bus[g].digital_mem_read_en   = rd_s[g];
        assign bus[g].digital_mem_write_en  = wr_s[g];
        assign bus[g].digital_mem_byte_size = size_s[g];
        assign bus[g].digital_mem_wdata     = wdata_s[g];
        assign data_o[g] = bus[g].digital_mem_data;
        assign rdy_o[g]  = bus[g].digital_mem_ready;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 3 : 0;
    endfunction

    function automatic int nbytes(input logic [3:0] sz);
        case (sz)
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 3;
            4'b1000, 4'b1111: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_rd(input int k, input logic [31:0] a);
        logic [31:0] r;
        logic [11:0] idx;
        for (int i = 0; i < 4; i++) begin
            idx = a[11:0] + 12'(i);
            r[8*i +: 8] = mem_m[k][idx];
        end
        return r;
    endfunction

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            rd_s[k] = 1'b0; wr_s[k] = 1'b0; addr_s[k] = '0; wdata_s[k] = '0; size_s[k] = '0;
        end
    endtask

    // One full handshake: latency, response data, hold stability, ready drop.
    task automatic txn(input int k, input bit do_rd, input bit do_wr, input logic [31:0] a,
                       input logic [3:0] sz, input logic [31:0] wd, input int hold,
                       output logic [31:0] rdat);
        int          n;
        logic [31:0] exp_d;
        logic [11:0] idx;
        exp_d = do_wr ? last_rd[k] : model_rd(k, a);
        @(negedge ramclk);
        addr_s[k] = a; rd_s[k] = do_rd; wr_s[k] = do_wr; size_s[k] = sz; wdata_s[k] = wd;
        n = 0;
        while (n < 300) begin
            @(posedge ramclk); #1;
            n++;
            if (rdy_o[k]) break;
            addr_s[k] = $urandom(); wdata_s[k] = $urandom(); size_s[k] = 4'($urandom());
        end
        chk($sformatf("lat%0d", k), 32'(n), 32'(lat_of(k) + 1));
        chk($sformatf("data%0d", k), data_o[k], exp_d);
        rdat = data_o[k];
        if (do_wr) begin
            for (int i = 0; i < nbytes(sz); i++) begin
                idx = a[11:0] + 12'(i);
                mem_m[k][idx] = wd[8*i +: 8];
            end
        end else begin
            last_rd[k] = exp_d;
        end
        for (int h = 0; h < hold; h++) begin
            addr_s[k] = $urandom(); wdata_s[k] = $urandom(); size_s[k] = 4'b1111;
            wr_s[k] = 1'($urandom()); rd_s[k] = ~wr_s[k] | 1'($urandom());
            @(posedge ramclk); #1;
            chk($sformatf("hold_rdy%0d", k), 32'(rdy_o[k]), 32'd1);
            chk($sformatf("hold_data%0d", k), data_o[k], exp_d);
        end
        rd_s[k] = 1'b0; wr_s[k] = 1'b0;
        @(posedge ramclk); #1;
        chk($sformatf("drop%0d", k), 32'(rdy_o[k]), 32'd0);
        @(posedge ramclk);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [11:0] lo;
        if ($urandom_range(0, 3) == 0) lo = 12'hFF8 + 12'($urandom_range(0, 7));
        else                           lo = 12'($urandom_range(0, 63));
        return {20'($urandom()), lo};
    endfunction

    function automatic logic [3:0] rnd_size();
        case ($urandom_range(0, 7))
            0: return 4'b0001;
            1: return 4'b0010;
            2: return 4'b0100;
            3: return 4'b1000;
            4: return 4'b1111;
            5: return 4'b0011;
            6: return 4'b0000;
            default: return 4'b1010;
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        logic [31:0] aw;
        int          n;
        bit          rdq, wrq;
        idle_all();
        for (int k = 0; k < 3; k++) last_rd[k] = '0;

        #17;
        for (int k = 0; k < 3; k++) begin
            chk("rst_rdy", 32'(rdy_o[k]), 32'd0);
            chk("rst_data", data_o[k], 32'd0);
        end
        @(negedge ramclk); rst = 1'b1;
        repeat (10) begin
            @(posedge ramclk); #1;
            for (int k = 0; k < 3; k++) chk("idle_rdy", 32'(rdy_o[k]), 32'd0);
        end

        // Known contents over the window the random phase touches.
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 19; w++) txn(k, 0, 1, 32'(4 * w), 4'b1111, $urandom(), 0, r);
            txn(k, 0, 1, 32'hFF8, 4'b1111, $urandom(), 0, r);
            txn(k, 0, 1, 32'hFFC, 4'b1111, $urandom(), 0, r);
        end

        txn(0, 0, 1, 32'h10, 4'b1111, 32'hDEADBEEF, 0, r);
        txn(0, 1, 0, 32'h10, 4'b0000, 32'h0, 0, r);
        chk("word_rd", r, 32'hDEADBEEF);
        txn(0, 0, 1, 32'h11, 4'b0001, 32'h000000AA, 0, r);
        txn(0, 1, 0, 32'h10, 4'b0000, 32'h0, 0, r);
        chk("part1_rd", r, 32'hDEADAAEF);
        txn(0, 0, 1, 32'h12, 4'b0010, 32'h00001234, 0, r);
        txn(0, 1, 0, 32'h10, 4'b0000, 32'h0, 0, r);
        chk("part2_rd", r, 32'h1234AAEF);
        txn(0, 0, 1, 32'hFFE, 4'b1111, 32'h44332211, 0, r);
        txn(0, 1, 0, 32'hFFE, 4'b0000, 32'h0, 0, r);
        chk("wrap_rd", r, 32'h44332211);
        txn(0, 1, 0, 32'h000, 4'b0000, 32'h0, 0, r);
        chk("wrap_lo", {16'h0, r[15:0]}, 32'h00004433);
        txn(0, 1, 0, 32'h1000, 4'b0000, 32'h0, 0, r);
        chk("alias", {16'h0, r[15:0]}, 32'h00004433);

        // Abort on the LATENCY=3 responder: request dropped after two edges.
        @(negedge ramclk);
        addr_s[1] = 32'h20; wr_s[1] = 1'b1; size_s[1] = 4'b1111; wdata_s[1] = 32'h5A5A5A5A;
        repeat (2) begin
            @(posedge ramclk); #1;
            chk("abort_busy", 32'(rdy_o[1]), 32'd0);
        end
        @(negedge ramclk); wr_s[1] = 1'b0;
        repeat (5) begin
            @(posedge ramclk); #1;
            chk("abort_rdy", 32'(rdy_o[1]), 32'd0);
        end
        aw = model_rd(1, 32'h20);
        txn(1, 1, 0, 32'h20, 4'b0000, 32'h0, 5, r);
        chk("abort_mem", r, aw);

        // LATENCY=0: illegal size and simultaneous read/write.
        aw = model_rd(2, 32'h30);
        txn(2, 0, 1, 32'h30, 4'b0011, 32'hFFFFFFFF, 0, r);
        txn(2, 1, 0, 32'h30, 4'b0000, 32'h0, 0, r);
        chk("illegal_sz", r, aw);
        txn(2, 1, 1, 32'h30, 4'b1111, 32'hA1B2C3D4, 0, r);
        txn(2, 1, 0, 32'h30, 4'b0000, 32'h0, 0, r);
        chk("both_wr", r, 32'hA1B2C3D4);

        // Reset asserted while a write is still in flight.
        @(negedge ramclk);
        addr_s[0] = 32'h24; wr_s[0] = 1'b1; size_s[0] = 4'b1111; wdata_s[0] = 32'hCAFEF00D;
        @(posedge ramclk); #2;
        rst = 1'b0; #1;
        chk("mid_rst_rdy", 32'(rdy_o[0]), 32'd0);
        chk("mid_rst_data", data_o[0], 32'd0);
        for (int k = 0; k < 3; k++) last_rd[k] = '0;
        @(negedge ramclk); idle_all();
        @(negedge ramclk); rst = 1'b1;
        @(posedge ramclk);
        txn(0, 1, 0, 32'h24, 4'b0000, 32'h0, 0, r);

        for (int t = 0; t < 150; t++) begin
            n   = $urandom_range(0, 2);
            wrq = 1'($urandom());
            rdq = ~wrq | 1'($urandom());
            txn(n, rdq, wrq, rnd_addr(), rnd_size(), $urandom(), $urandom_range(0, 3), r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
